// File: rtl/cnt_pair_checker_if.sv
// Bundle of the checker's sampled count streams, clear and status outputs.
// master: drives clr/up_cnt/down_cnt, reads status; slave: the checker.
interface cnt_pair_checker_if #(
    parameter int W     = 4,
    parameter int ERR_W = 8
);
    logic             clr;
    logic [W-1:0]     up_cnt;
    logic [W-1:0]     down_cnt;
    logic             locked;
    logic             err_flag;
    logic [ERR_W-1:0] up_err_cnt;
    logic [ERR_W-1:0] down_err_cnt;
    logic [1:0]       state_o;

    modport master (
        output clr, up_cnt, down_cnt,
        input  locked, err_flag, up_err_cnt, down_err_cnt, state_o
    );

    modport slave (
        input  clr, up_cnt, down_cnt,
        output locked, err_flag, up_err_cnt, down_err_cnt, state_o
    );
endinterface

// File: rtl/cnt_pair_checker.sv
// Receive-side checker for an up/down counter pair: locks on clean steps,
// counts per-stream errors while locked. Ports: clk, reset_n, bus (slave).
module cnt_pair_checker #(
    parameter int W        = 4,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cnt_pair_checker_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_V = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_V = 4'(LOSS_CNT);

    state_t           state, state_n;
    logic [W-1:0]     prev_up, prev_down;
    logic [3:0]       run, run_n;
    logic [3:0]       miss, miss_n;
    logic             err_q, err_n;
    logic             lock_q;
    logic [ERR_W-1:0] up_err, up_err_n;
    logic [ERR_W-1:0] dn_err, dn_err_n;

    // Expected values held in W-bit nets so the wrap is kept modulo 2^W.
    logic [W-1:0] up_exp, dn_exp;
    logic         up_ok, dn_ok;
    logic [3:0]   run_inc, miss_inc;

    assign up_exp   = prev_up + 1'b1;
    assign dn_exp   = prev_down - 1'b1;
    assign up_ok    = (bus.up_cnt == up_exp);
    assign dn_ok    = (bus.down_cnt == dn_exp);
    assign run_inc  = run + 4'd1;
    assign miss_inc = miss + 4'd1;

    always_comb begin
        state_n  = state;
        run_n    = run;
        miss_n   = miss;
        err_n    = err_q;
        up_err_n = up_err;
        dn_err_n = dn_err;
        unique case (state)
            IDLE: begin
                state_n = ACQ;
            end
            ACQ: begin
                // Held or bad values only restart the run; never errors.
                if (up_ok && dn_ok) begin
                    if (run_inc == LOCK_V) begin
                        state_n = LOCKED;
                        run_n   = 4'd0;
                        miss_n  = 4'd0;
                    end else begin
                        run_n = run_inc;
                    end
                end else begin
                    run_n = 4'd0;
                end
            end
            LOCKED: begin
                if (!up_ok && (up_err != '1))
                    up_err_n = up_err + 1'b1;
                if (!dn_ok && (dn_err != '1))
                    dn_err_n = dn_err + 1'b1;
                if (!up_ok || !dn_ok) begin
                    err_n  = 1'b1;
                    miss_n = miss_inc;
                    if (miss_inc == LOSS_V) begin
                        state_n = ACQ;
                        run_n   = 4'd0;
                        miss_n  = 4'd0;
                    end
                end else begin
                    miss_n = 4'd0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // Clear wins over any same-edge increment or flag set.
        if (bus.clr) begin
            err_n    = 1'b0;
            up_err_n = '0;
            dn_err_n = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            prev_up   <= '0;
            prev_down <= '0;
            run       <= '0;
            miss      <= '0;
            err_q     <= 1'b0;
            lock_q    <= 1'b0;
            up_err    <= '0;
            dn_err    <= '0;
        end else begin
            state     <= state_n;
            prev_up   <= bus.up_cnt;
            prev_down <= bus.down_cnt;
            run       <= run_n;
            miss      <= miss_n;
            err_q     <= err_n;
            lock_q    <= (state_n == LOCKED);
            up_err    <= up_err_n;
            dn_err    <= dn_err_n;
        end
    end

    assign bus.locked       = lock_q;
    assign bus.err_flag     = err_q;
    assign bus.up_err_cnt   = up_err;
    assign bus.down_err_cnt = dn_err;
    assign bus.state_o      = state;
endmodule
